// File: rtl/turbo_output_packer.sv
// Packs the turbo encoder's serial bit-pair stream into WORD_W-bit words, tags frame ends
// and buffers them in a small FIFO. Optional macro PACKER_DROP_COUNT_EN adds a drop counter.
module turbo_output_packer #(
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_PAIRS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0,
  input  logic              in1,
  input  logic              in_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done,
  output logic              overflow
`ifdef PACKER_DROP_COUNT_EN
  ,
  output logic [7:0]        drop_count
`endif
);

  localparam int unsigned PAIRS_PER_WORD = WORD_W / 2;
  localparam int unsigned PAIR_W         = $clog2(FRAME_PAIRS) + 1;
  localparam int unsigned SLOT_W         = $clog2(PAIRS_PER_WORD);
  localparam int unsigned AW             = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE, FILL} state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } entry_t;

  state_t              state;
  state_t              state_nxt;
  logic [PAIR_W-1:0]   pair_cnt;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [WORD_W-1:0]   shreg;
  entry_t              mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;

  logic                frame_end_c;
  logic                word_done_c;
  logic [WORD_W-1:0]   word_c;
  logic                empty_c;
  logic                full_c;
  logic                pop_c;
  logic                push_c;
  logic                drop_c;

  // In IDLE no pair of the frame is in yet, so only a one-pair frame can end there.
  always_comb begin
    frame_end_c = 1'b0;
    if (in_valid) begin
      if (state == IDLE) frame_end_c = (FRAME_PAIRS == 1);
      else               frame_end_c = (pair_cnt == PAIR_W'(FRAME_PAIRS - 1));
    end
  end

  assign word_done_c = in_valid && ((slot_cnt == SLOT_W'(PAIRS_PER_WORD - 1)) || frame_end_c);
  assign word_c      = shreg | (WORD_W'({in1, in0}) << {slot_cnt, 1'b0});

  // Extra pointer bit separates full from empty.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c   = !empty_c && out_ready;
  assign push_c  = word_done_c && (!full_c || pop_c);
  assign drop_c  = word_done_c && full_c && !pop_c;

  assign out_valid = !empty_c;
  assign out_data  = empty_c ? '0 : mem[rd_ptr[AW-1:0]].data;
  assign out_last  = !empty_c && mem[rd_ptr[AW-1:0]].last;

  // Frame-level state: IDLE until the first pair of a frame arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && !frame_end_c) state_nxt = FILL;
      FILL:    if (frame_end_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pair/slot counters and partial word; both clear at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt <= '0;
      slot_cnt <= '0;
      shreg    <= '0;
    end else if (in_valid) begin
      if (frame_end_c) begin
        pair_cnt <= '0;
        slot_cnt <= '0;
        shreg    <= '0;
      end else begin
        pair_cnt <= pair_cnt + PAIR_W'(1);
        if (word_done_c) begin
          slot_cnt <= '0;
          shreg    <= '0;
        end else begin
          slot_cnt <= slot_cnt + SLOT_W'(1);
          shreg    <= word_c;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= '{last: frame_end_c, data: word_c};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
      frame_done <= frame_end_c;
      if (drop_c) overflow <= 1'b1;
    end
  end

`ifdef PACKER_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                              drop_count <= '0;
    else if (drop_c && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: doc/turbo_output_packer.md
Name: turbo_output_packer

Overview:
- Downstream stage of the turbo encoder. Consumes the encoder's serial two-bit output stream (out0/out1 with valid), one bit-pair per clk.
- Packs pairs into WORD_W-bit words, marks frame boundaries, and buffers words in a small FIFO.
- Presents words on a valid/ready interface to the channel/host side.
- The encoder cannot be stalled, so the input side has no ready; FIFO overrun is detected and flagged.

Parameters:
- WORD_W, 8, output word width in bits; even, >= 4.
- FIFO_DEPTH, 4, word FIFO entries; power of 2, >= 2.
- FRAME_PAIRS, 64, bit-pairs per encoded frame (data + termination); >= 1.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in0  input  1  encoder out0 bit.
- in1  input  1  encoder out1 bit.
- in_valid  input  1  pair valid; sampled every clk, no backpressure.
- out_data  output  WORD_W  packed word at FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts; pop when out_valid && out_ready.
- out_last  output  1  head word is the final word of a frame.
- frame_done  output  1  one-clk pulse when a frame's last word is written to, or dropped from, the FIFO.
- overflow  output  1  sticky: a completed word was dropped.

Behaviour:
Reset:
- reset high at an edge clears the shift register, pair counter, word-slot counter, FIFO pointers, FSM (IDLE), overflow and frame_done.
- After that edge: out_valid=0, out_last=0, out_data=0, frame_done=0, overflow=0.
- Reset mid-frame discards the partial word and all FIFO contents. The next accepted pair is pair 0 of a new frame.

Packing:
- Pair k within a word occupies bits [2k+1:2k]: in0 goes to bit 2k, in1 to bit 2k+1. LSB-first; pair 0 goes in bits [1:0].
- A word completes when WORD_W/2 pairs have been accepted, or when the frame's last pair (pair FRAME_PAIRS-1) is accepted.
- A short final word has unfilled upper bits = 0.
- The completed word is written to the FIFO at the same edge that accepts its final pair, with its last flag = (frame end).

FSM:
- IDLE: no pairs of the current frame accepted. in_valid=1 → accept pair 0, go to FILL. If FRAME_PAIRS==1, the word completes immediately and the FSM stays in IDLE.
- FILL: accept pairs on in_valid. When the pair counter reaches FRAME_PAIRS-1 and in_valid=1 → write last word, pulse frame_done next cycle, clear counters, return to IDLE.
- in_valid=0 cycles are idle gaps in any state; they do not advance counters.

Latency:
- out_valid rises the clk after the edge that wrote the first word into an empty FIFO. There is no combinational path from in_* to out_*.

FIFO:
- Head word drives out_data/out_last directly; out_data holds stable while out_valid && !out_ready.
- Pop on out_valid && out_ready.
- Simultaneous push and pop when full: both occur, no overflow.
- Push while full without pop: word dropped and overflow set (stays 1 until reset). A dropped frame-last word still pulses frame_done.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished with an extra pointer bit.

Arithmetic:
- Pair counter width = clog2(FRAME_PAIRS)+1; it wraps to 0 only at frame end.
- Word-slot counter wraps at WORD_W/2 or at frame end, whichever comes first.

Optional Feature:
- Macro: PACKER_DROP_COUNT_EN.
- When defined:
  - Adds output port drop_count, 8 bits: the number of dropped words since reset, saturating at 255.
  - Increments in the same edge that sets overflow.
  - Reset value 0.
- When undefined: the port and counter are absent. overflow behaviour is unchanged.

Test Plan:
- WORD_W=8: 4 consecutive pairs in0=1,in1=0, out_ready=1 → one word 0x55 with out_valid high exactly 1 clk after 4th pair edge.
- FRAME_PAIRS=6, six pairs (1,1), back-to-back → words 0xFF (out_last=0) then 0x0F (out_last=1); frame_done pulses once; next pair starts fresh frame.
- out_ready=0, FIFO_DEPTH=4, push 5 full words 0x01..0x05 (in_valid gaps allowed):
  - overflow=1 after 5th word.
  - Draining yields 0x01..0x04 only.
  - drop_count=1 when PACKER_DROP_COUNT_EN is defined.
- FIFO full, out_ready=1 in the same cycle a 5th word completes → no overflow, all 5 words delivered in order.
- Assert reset after 3 pairs of a word with 2 words queued → out_valid=0 next clk; following 4 pairs (0,1) produce 0xAA with out_last per new frame count.
- Random in_valid gaps (50%) over 3 frames, FRAME_PAIRS=64 → output bitstream equals input pairs LSB-first, 16 words per frame, out_last on every 16th word.
